// File: rtl/cong_nbit_pipe_pkg.sv
// Shared defaults for the pipelined adder/subtractor and the derivation of its stage count.
// Imported by the RTL and by the bench, so both use the same geometry.
package cong_nbit_pipe_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // One pipeline stage per SLICE-bit chunk; WIDTH must be a multiple of SLICE.
  function automatic int stages_of(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/cong_slice_add.sv
// Combinational SLICE-bit ripple adder built as a full-adder chain.
// Also exposes the carry into its MSB so the last stage can form the signed-overflow flag.
module cong_slice_add #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];
  assign cmsb = c[SLICE-1];

endmodule

// File: rtl/cong_nbit_pipe.sv
// Pipelined N-bit adder/subtractor: one SLICE-bit chunk per stage, registered carry between
// stages, skew/deskew registers so all slices of one op leave together, valid/ready handshake.
module cong_nbit_pipe
  import cong_nbit_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages_of(WIDTH, SLICE);

  logic             advance;
  logic [WIDTH-1:0] b_cond;
  logic             c0;

  // Subtraction as A + ~B + ~Cin, so Cout=1 means "no borrow".
  assign b_cond   = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  // The whole pipe moves in lockstep; it only holds when a finished result is not taken.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SLICE;
    localparam int REM  = WIDTH - DONE;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic [DONE-1:0]  sum_d;
    logic             v_in;
    logic             c_in;
    logic             c_out;
    logic             c_msb;
    logic             vld_q;
    logic             cy_q;
    logic [DONE-1:0]  sum_q;

    if (k == 0) begin : g_src
      assign v_in  = in_valid;
      assign c_in  = c0;
      assign a_sl  = a[SLICE-1:0];
      assign b_sl  = b_cond[SLICE-1:0];
      assign sum_d = s_sl;
    end else begin : g_src
      assign v_in  = g_stage[k-1].vld_q;
      assign c_in  = g_stage[k-1].cy_q;
      assign a_sl  = g_stage[k-1].g_skew.a_q[SLICE-1:0];
      assign b_sl  = g_stage[k-1].g_skew.b_q[SLICE-1:0];
      assign sum_d = {s_sl, g_stage[k-1].sum_q};
    end

    cong_slice_add #(
      .SLICE(SLICE)
    ) u_add (
      .a   (a_sl),
      .b   (b_sl),
      .cin (c_in),
      .sum (s_sl),
      .cout(c_out),
      .cmsb(c_msb)
    );

    // NOTE: state uses non-blocking assignments and an async reset, so every stage
    // samples the previous stage's old value and reset clears in-flight ops at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        vld_q <= v_in;
        cy_q  <= c_out;
        sum_q <= sum_d;
      end
    end

    // Skew: slices not yet added travel down the pipe, shifted so the next slice sits at bit 0.
    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_in
        assign a_d = a[WIDTH-1:SLICE];
        assign b_d = b_cond[WIDTH-1:SLICE];
      end else begin : g_in
        assign a_d = g_stage[k-1].g_skew.a_q[REM+SLICE-1:SLICE];
        assign b_d = g_stage[k-1].g_skew.b_q[REM+SLICE-1:SLICE];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_msb ^ c_out;
        end
      end
    end else begin : g_mid
      // Carry into the slice MSB only matters for the top slice.
      logic unused_cmsb;
      assign unused_cmsb = c_msb;
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].cy_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
